// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, then releases sys_rst_n.
// Define PLL_FAIL_RECOVER_EN to leave FAIL after LOCK_TIMEOUT_CYC cycles instead of holding it until rst_n.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
  parameter int unsigned STABLE_CYC       = 1024,
  parameter int unsigned MAX_RETRY        = 4
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lol_cnt
);

  localparam int unsigned MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_q;
  logic             locked_s;

  // NOTE: non-blocking assignments make sync_q and locked_s two distinct flops;
  // blocking ones would collapse the chain into a single stage.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

  // Outputs are assigned alongside each state change so they are registered
  // and move on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      lol_cnt   <= '0;
    end else begin
      unique case (state)
        RESET_PLL: begin
          if (cnt == PULSE_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt       <= '0;
            pll_rst   <= 1'b1;
            retry_cnt <= retry_cnt + 4'd1;
            if (retry_cnt + 4'd1 == RETRY_LIMIT) begin
              state <= FAIL;
              fail  <= 1'b1;
            end else begin
              state <= RESET_PLL;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STABLE: begin
          if (!locked_s) begin
            // A dropout restarts qualification with a fresh timeout window.
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
            retry_cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          if (!locked_s) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            if (lol_cnt != 8'hFF) lol_cnt <= lol_cnt + 8'd1;
          end
        end

        FAIL: begin
`ifdef PLL_FAIL_RECOVER_EN
          if (cnt == TIMEOUT_LAST) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            fail      <= 1'b0;
            retry_cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`else
          state <= FAIL;
`endif
        end

        default: begin
          state     <= RESET_PLL;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short sim parameters (4/100/8/2).
// Inputs change and outputs are sampled on the falling edge of refclk.
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] lol_cnt;

  int total = 0;
  int bad   = 0;

  // Output snapshot layout: {pll_rst, sys_rst_n, ready, fail, retry_cnt[3:0], lol_cnt[7:0]}
  logic [15:0] exp_v;

  pll_lock_supervisor #(
    .RST_PULSE_CYC   (4),
    .LOCK_TIMEOUT_CYC(100),
    .STABLE_CYC      (8),
    .MAX_RETRY       (2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .lol_cnt   (lol_cnt)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  function automatic logic [15:0] outs();
    return {pll_rst, sys_rst_n, ready, fail, retry_cnt, lol_cnt};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Leaves the bench on the falling edge where rst_n was released ("edge 0").
  task automatic apply_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge refclk);
      if (ready === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    tick(3);
    exp_v = {4'b1000, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL reset_values: got %h want %h", outs(), exp_v); end
    pll_locked = 1'b1;
    tick(4);
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL reset_ignores_lock: got %h want %h", outs(), exp_v); end
  endtask

  task automatic test_bring_up();
    apply_reset();
    tick(3);
    exp_v = {4'b1000, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL bring_up_pulse_high: got %h want %h", outs(), exp_v); end
    tick(1);
    exp_v = {4'b0000, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL bring_up_pulse_end: got %h want %h", outs(), exp_v); end
    tick(16);
    pll_locked = 1'b1;
    // First sampled on edge 21; 2 sync cycles then 8 in STABLE puts RUN on edge 31.
    tick(10);
    exp_v = {4'b0000, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL bring_up_early: got %h want %h", outs(), exp_v); end
    tick(1);
    exp_v = {4'b0110, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL bring_up_run: got %h want %h", outs(), exp_v); end
  endtask

  task automatic test_loss_of_lock();
    pll_locked = 1'b0;
    tick(2);
    exp_v = {4'b0110, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL lol_before: got %h want %h", outs(), exp_v); end
    tick(1);
    exp_v = {4'b1000, 4'd0, 8'd1};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL lol_within3: got %h want %h", outs(), exp_v); end
    tick(3);
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL lol_pulse_high: got %h want %h", outs(), exp_v); end
    tick(1);
    exp_v = {4'b0000, 4'd0, 8'd1};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL lol_pulse_end: got %h want %h", outs(), exp_v); end
    // Stay unlocked through one timeout so the next RUN entry has a retry to clear.
    tick(99);
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL lol_pre_timeout: got %h want %h", outs(), exp_v); end
    tick(1);
    exp_v = {4'b1000, 4'd1, 8'd1};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL lol_timeout_retry: got %h want %h", outs(), exp_v); end
    tick(4);
    exp_v = {4'b0000, 4'd1, 8'd1};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL lol_second_pulse_end: got %h want %h", outs(), exp_v); end
    pll_locked = 1'b1;
    tick(10);
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL lol_relock_early: got %h want %h", outs(), exp_v); end
    tick(1);
    exp_v = {4'b0110, 4'd0, 8'd1};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL lol_relock_run: got %h want %h", outs(), exp_v); end
  endtask

  task automatic test_lol_saturation();
    int exp_lol;
    bit ok;
    exp_lol = 1;
    for (int ev = 0; ev < 255; ev++) begin
      pll_locked = 1'b0;
      wait_ready(1'b0, 6, ok);
      total++; if (!ok) begin bad++; $display("FAIL sat_drop_timeout: event %0d ready got %b want 0", ev, ready); end
      tick(5);
      pll_locked = 1'b1;
      wait_ready(1'b1, 20, ok);
      total++; if (!ok) begin bad++; $display("FAIL sat_relock_timeout: event %0d ready got %b want 1", ev, ready); end
      exp_lol = (exp_lol < 255) ? exp_lol + 1 : 255;
      total++;
      if (lol_cnt !== 8'(exp_lol)) begin
        bad++;
        $display("FAIL sat_lol_cnt: event %0d got %0d want %0d", ev, lol_cnt, exp_lol);
      end
    end
  endtask

  task automatic test_flicker();
    apply_reset();
    tick(20);
    pll_locked = 1'b1;
    // STABLE entered on edge 23; a one-cycle drop sampled on edge 27 is seen at count 5.
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(4);
    exp_v = {4'b0000, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL flicker_no_early_run: got %h want %h", outs(), exp_v); end
    tick(6);
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL flicker_full_window: got %h want %h", outs(), exp_v); end
    tick(1);
    exp_v = {4'b0110, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL flicker_run: got %h want %h", outs(), exp_v); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    tick(54);
    exp_v = {4'b0000, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL mid_wait_lock: got %h want %h", outs(), exp_v); end
    #2 rst_n = 1'b0;
    #1;
    exp_v = {4'b1000, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL mid_async_wait: got %h want %h", outs(), exp_v); end

    apply_reset();
    pll_locked = 1'b1;
    wait_ready(1'b1, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_run_timeout: ready got %b want 1", ready); end
    pll_locked = 1'b0;
    wait_ready(1'b0, 6, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_drop_timeout: ready got %b want 0", ready); end
    tick(5);
    pll_locked = 1'b1;
    wait_ready(1'b1, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_relock_timeout: ready got %b want 1", ready); end
    exp_v = {4'b0110, 4'd0, 8'd1};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL mid_run_state: got %h want %h", outs(), exp_v); end
    #2 rst_n = 1'b0;
    #1;
    exp_v = {4'b1000, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL mid_async_run: got %h want %h", outs(), exp_v); end
  endtask

  task automatic test_timeout_fail();
    apply_reset();
    tick(103);
    exp_v = {4'b0000, 4'd0, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL to_before_first: got %h want %h", outs(), exp_v); end
    tick(1);
    exp_v = {4'b1000, 4'd1, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL to_first_retry: got %h want %h", outs(), exp_v); end
    tick(4);
    exp_v = {4'b0000, 4'd1, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL to_second_pulse_end: got %h want %h", outs(), exp_v); end
    tick(99);
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL to_before_second: got %h want %h", outs(), exp_v); end
    tick(1);
    exp_v = {4'b1001, 4'd2, 8'd0};
    total++; if (outs() !== exp_v) begin bad++; $display("FAIL to_enter_fail: got %h want %h", outs(), exp_v); end
`ifdef PLL_FAIL_RECOVER_EN
    begin
      bit ok;
      tick(99);
      total++; if (outs() !== exp_v) begin bad++; $display("FAIL rec_still_fail: got %h want %h", outs(), exp_v); end
      tick(1);
      exp_v = {4'b1000, 4'd0, 8'd0};
      total++; if (outs() !== exp_v) begin bad++; $display("FAIL rec_exit_fail: got %h want %h", outs(), exp_v); end
      tick(4);
      exp_v = {4'b0000, 4'd0, 8'd0};
      total++; if (outs() !== exp_v) begin bad++; $display("FAIL rec_pulse_end: got %h want %h", outs(), exp_v); end
      pll_locked = 1'b1;
      wait_ready(1'b1, 20, ok);
      total++; if (!ok) begin bad++; $display("FAIL rec_run_timeout: ready got %b want 1", ready); end
      exp_v = {4'b0110, 4'd0, 8'd0};
      total++; if (outs() !== exp_v) begin bad++; $display("FAIL rec_run: got %h want %h", outs(), exp_v); end
    end
`else
    for (int i = 0; i < 1000; i++) begin
      if (i == 10) pll_locked = 1'b1;
      tick(1);
      total++;
      if (outs() !== exp_v) begin
        bad++;
        $display("FAIL fail_sticky: cycle %0d got %h want %h", i, outs(), exp_v);
        break;
      end
    end
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    test_reset();
    test_bring_up();
    test_loss_of_lock();
    test_lol_saturation();
    test_flicker();
    test_reset_mid();
    test_timeout_fail();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
